// File: rtl/button_debounce_sync.sv
// button_debounce_sync: per-channel 2-FF synchroniser and debounce FSM with registered level and edge outputs
module button_debounce_sync #(
  parameter int N_CH          = 2,
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_W         = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_clean,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall
);
  typedef enum logic [1:0] {ST_LO, ST_WHI, ST_HI, ST_WLO} state_t;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_CYCLES - 1);
  logic [N_CH-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic clean_q, rise_q, fall_q;
    always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      case (state)
        ST_LO:
          if (sync2[g]) begin
            nxt     = ST_WHI;
            cnt_nxt = CNT_W'(1);
          end
        ST_WHI:
          if (!sync2[g]) begin
            nxt     = ST_LO;
            cnt_nxt = '0;
          end else if (cnt == LIMIT) begin
            nxt     = ST_HI;
            cnt_nxt = '0;
          end else cnt_nxt = cnt + 1'b1;
        ST_HI:
          if (!sync2[g]) begin
            nxt     = ST_WLO;
            cnt_nxt = CNT_W'(1);
          end
        ST_WLO:
          if (sync2[g]) begin
            nxt     = ST_HI;
            cnt_nxt = '0;
          end else if (cnt == LIMIT) begin
            nxt     = ST_LO;
            cnt_nxt = '0;
          end else cnt_nxt = cnt + 1'b1;
        default: begin
          nxt     = ST_LO;
          cnt_nxt = '0;
        end
      endcase
    end
    // Outputs are decoded from the next state so they change on the accepting edge
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state   <= ST_LO;
        cnt     <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state   <= nxt;
        cnt     <= cnt_nxt;
        clean_q <= (nxt == ST_HI) || (nxt == ST_WLO);
        rise_q  <= (state == ST_WHI) && (nxt == ST_HI);
        fall_q  <= (state == ST_WLO) && (nxt == ST_LO);
      end
    assign btn_clean[g] = clean_q;
    assign btn_rise[g]  = rise_q;
    assign btn_fall[g]  = fall_q;
  end
endmodule

// File: tb/tb_button_debounce_sync.sv
// tb_button_debounce_sync: directed checks of debounce latency, glitch rejection and reset behaviour
module tb_button_debounce_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_clean, btn_rise, btn_fall;
  int n_cmp = 0;
  int n_bad = 0;
  int rises = 0;
  int falls = 0;
  always #10 clk = ~clk;
  button_debounce_sync #(.N_CH(2), .STABLE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .btn_clean(btn_clean),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rise_fall_exclusive", 32'(btn_rise & btn_fall), 32'd0);
  endtask
  task automatic ticks(input int n);
    repeat (n) tick();
  endtask
  task automatic outs(input string tag, input logic [1:0] c, input logic [1:0] r, input logic [1:0] f);
    chk({tag, "_clean"}, 32'(btn_clean), 32'(c));
    chk({tag, "_rise"}, 32'(btn_rise), 32'(r));
    chk({tag, "_fall"}, 32'(btn_fall), 32'(f));
  endtask
  initial begin
    // reset with both pads high, then release: accept after six edges
    btn_raw = 2'b11;
    #2 rst_n = 1'b0;
    ticks(3);
    outs("rst", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    ticks(5);
    outs("rel_e4", 2'b00, 2'b00, 2'b00);
    tick();
    outs("rel_e5", 2'b11, 2'b11, 2'b00);
    tick();
    outs("rel_hold", 2'b11, 2'b00, 2'b00);
    btn_raw = 2'b00;
    ticks(6);
    outs("drop_e5", 2'b00, 2'b00, 2'b11);
    tick();
    outs("drop_hold", 2'b00, 2'b00, 2'b00);
    // clean press on ch0
    btn_raw = 2'b01;
    ticks(5);
    outs("press_e4", 2'b00, 2'b00, 2'b00);
    tick();
    outs("press_e5", 2'b01, 2'b01, 2'b00);
    tick();
    outs("press_hold", 2'b01, 2'b00, 2'b00);
    // clean release on ch0
    btn_raw = 2'b00;
    ticks(5);
    outs("release_e4", 2'b01, 2'b00, 2'b00);
    tick();
    outs("release_e5", 2'b00, 2'b00, 2'b01);
    tick();
    outs("release_hold", 2'b00, 2'b00, 2'b00);
    // bounce: toggle every 2 cycles for 12 cycles, then hold high
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = ((i / 2) % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      rises += int'(btn_rise[0]);
      chk("bounce_clean", 32'(btn_clean), 32'd0);
    end
    btn_raw = 2'b01;
    for (int j = 0; j < 5; j++) begin
      tick();
      rises += int'(btn_rise[0]);
      chk("bounce_wait_clean", 32'(btn_clean), 32'd0);
    end
    tick();
    rises += int'(btn_rise[0]);
    outs("bounce_e5", 2'b01, 2'b01, 2'b00);
    for (int j = 0; j < 4; j++) begin
      tick();
      rises += int'(btn_rise[0]);
    end
    chk("bounce_rise_count", 32'(rises), 32'd1);
    // three-cycle low glitch from a clean high level
    falls = 0;
    btn_raw = 2'b00;
    for (int j = 0; j < 3; j++) begin
      tick();
      falls += int'(btn_fall[0]);
    end
    btn_raw = 2'b01;
    for (int j = 0; j < 10; j++) begin
      tick();
      falls += int'(btn_fall[0]);
      chk("glitch_clean", 32'(btn_clean), 32'd1);
    end
    chk("glitch_fall_count", 32'(falls), 32'd0);
    btn_raw = 2'b00;
    ticks(6);
    outs("glitch_after_e5", 2'b00, 2'b00, 2'b01);
    tick();
    // simultaneous press and release on both channels
    btn_raw = 2'b11;
    ticks(5);
    outs("sim_e4", 2'b00, 2'b00, 2'b00);
    tick();
    outs("sim_e5", 2'b11, 2'b11, 2'b00);
    tick();
    outs("sim_hold", 2'b11, 2'b00, 2'b00);
    btn_raw = 2'b00;
    ticks(6);
    outs("sim_fall_e5", 2'b00, 2'b00, 2'b11);
    tick();
    // ch1 high, ch0 mid-count when reset asserts
    btn_raw = 2'b10;
    ticks(6);
    outs("ch1_up", 2'b10, 2'b10, 2'b00);
    tick();
    btn_raw = 2'b11;
    ticks(4);
    outs("pre_rst", 2'b10, 2'b00, 2'b00);
    rst_n = 1'b0;
    #1;
    outs("mid_rst", 2'b00, 2'b00, 2'b00);
    ticks(2);
    outs("mid_rst_held", 2'b00, 2'b00, 2'b00);
    rst_n = 1'b1;
    ticks(5);
    outs("post_rst_e4", 2'b00, 2'b00, 2'b00);
    tick();
    outs("post_rst_e5", 2'b11, 2'b11, 2'b00);
    tick();
    outs("post_rst_hold", 2'b11, 2'b00, 2'b00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
